instr_fetch_unit: RTL and testbench

- Owns the program counter, the 8-level hardware return stack and the program-memory read port of the PIC16F-style core.
- It is the responder to the instruction decoder's fetch controls: it acts on incr_pc_en (advance PC), instr_rd_en (fetch the word at PC) and the branch, call and return strobes.
- It returns the fetched word to the decoder on instr_current.
- Program memory sits behind a req/valid handshake with variable latency.

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, circular return stack and a
// req/valid program-memory fetch FSM that feeds instr_current to the decoder.
module instr_fetch_unit #(
   parameter int                  PC_WIDTH     = 13,
   parameter int                  INSTR_WIDTH  = 14,
   parameter int                  STACK_DEPTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   incr_pc_en,
   input  logic                   instr_rd_en,
   input  logic                   pc_load_en,
   input  logic [PC_WIDTH-1:0]    pc_load_addr,
   input  logic                   stack_push_en,
   input  logic                   stack_pop_en,
   input  logic                   flush_en,
   output logic [PC_WIDTH-1:0]    pmem_addr,
   output logic                   pmem_rd_req,
   input  logic [INSTR_WIDTH-1:0] pmem_rd_data,
   input  logic                   pmem_rd_valid,
   output logic [INSTR_WIDTH-1:0] instr_current,
   output logic                   fetch_busy,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic                   stack_overflow,
   output logic                   stack_underflow,
   output logic                   stack_conflict
);

   // state | meaning
   // IDLE  | no fetch outstanding
   // REQ   | request out, data will load instr_current
   // DROP  | request out after a flush, data will be discarded
   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   localparam int SP_W  = $clog2(STACK_DEPTH);
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);

   state_t                  r_state, w_state_nxt;
   logic [PC_WIDTH-1:0]     r_pc, w_pc_nxt;
   logic [PC_WIDTH-1:0]     r_addr, w_addr_nxt;
   logic                    r_req, w_req_nxt;
   logic [INSTR_WIDTH-1:0]  r_instr, w_instr_nxt;
   logic                    r_busy;
   logic [SP_W-1:0]         r_sp, w_sp_dec;
   logic [CNT_W-1:0]        r_count;
   logic                    r_ovf, r_unf, r_cfl;
   logic [PC_WIDTH-1:0]     r_stack [STACK_DEPTH];
   logic                    w_push, w_pop, w_conflict;

   assign w_push     = stack_push_en & ~stack_pop_en;
   assign w_pop      = stack_pop_en & ~stack_push_en;
   assign w_conflict = stack_push_en & stack_pop_en;
   assign w_sp_dec   = r_sp - SP_W'(1);

   // A cancelled pop (conflict) leaves incr_pc_en free to win.
   always_comb begin
      w_pc_nxt = r_pc;
      if (pc_load_en)
         w_pc_nxt = pc_load_addr;
      else if (w_pop)
         w_pc_nxt = r_stack[w_sp_dec];
      else if (incr_pc_en)
         w_pc_nxt = r_pc + PC_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc    <= RESET_VECTOR;
         r_sp    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
         r_cfl   <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_push) begin
            r_sp <= r_sp + SP_W'(1);
            if (r_count == CNT_W'(STACK_DEPTH))
               r_ovf <= 1'b1;
            else
               r_count <= r_count + CNT_W'(1);
         end else if (w_pop) begin
            r_sp <= w_sp_dec;
            if (r_count == '0)
               r_unf <= 1'b1;
            else
               r_count <= r_count - CNT_W'(1);
         end
         if (w_conflict)
            r_cfl <= 1'b1;
      end
   end

   // Stack contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (w_push)
         r_stack[r_sp] <= r_pc;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_req_nxt   = r_req;
      w_instr_nxt = r_instr;
      case (r_state)
         IDLE: begin
            if (flush_en) begin
               w_instr_nxt = '0;
            end else if (instr_rd_en) begin
               w_addr_nxt  = r_pc;
               w_req_nxt   = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (pmem_rd_valid) begin
               w_instr_nxt = flush_en ? '0 : pmem_rd_data;
               w_req_nxt   = 1'b0;
               w_state_nxt = IDLE;
            end else if (flush_en) begin
               w_instr_nxt = '0;
               w_state_nxt = DROP;
            end
         end
         DROP: begin
            if (flush_en)
               w_instr_nxt = '0;
            if (pmem_rd_valid) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_req_nxt   = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_addr  <= RESET_VECTOR;
         r_req   <= 1'b0;
         r_instr <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_req   <= w_req_nxt;
         r_instr <= w_instr_nxt;
         r_busy  <= (w_state_nxt != IDLE);
      end
   end

   assign pmem_addr       = r_addr;
   assign pmem_rd_req     = r_req;
   assign instr_current   = r_instr;
   assign fetch_busy      = r_busy;
   assign pc_out          = r_pc;
   assign stack_overflow  = r_ovf;
   assign stack_underflow = r_unf;
   assign stack_conflict  = r_cfl;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC update, return stack, fetch FSM,
// flush and asynchronous reset, with hand-computed expectations.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        incr_pc_en, instr_rd_en, pc_load_en;
   logic [12:0] pc_load_addr;
   logic        stack_push_en, stack_pop_en, flush_en;
   logic [12:0] pmem_addr;
   logic        pmem_rd_req;
   logic [13:0] pmem_rd_data;
   logic        pmem_rd_valid;
   logic [13:0] instr_current;
   logic        fetch_busy;
   logic [12:0] pc_out;
   logic        stack_overflow, stack_underflow, stack_conflict;

   int n_checks = 0;
   int n_fails  = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .incr_pc_en     (incr_pc_en),
      .instr_rd_en    (instr_rd_en),
      .pc_load_en     (pc_load_en),
      .pc_load_addr   (pc_load_addr),
      .stack_push_en  (stack_push_en),
      .stack_pop_en   (stack_pop_en),
      .flush_en       (flush_en),
      .pmem_addr      (pmem_addr),
      .pmem_rd_req    (pmem_rd_req),
      .pmem_rd_data   (pmem_rd_data),
      .pmem_rd_valid  (pmem_rd_valid),
      .instr_current  (instr_current),
      .fetch_busy     (fetch_busy),
      .pc_out         (pc_out),
      .stack_overflow (stack_overflow),
      .stack_underflow(stack_underflow),
      .stack_conflict (stack_conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      incr_pc_en = 0; instr_rd_en = 0; pc_load_en = 0; pc_load_addr = '0;
      stack_push_en = 0; stack_pop_en = 0; flush_en = 0;
      pmem_rd_data = '0; pmem_rd_valid = 0;
      #12;
      chk("rst_pc",    32'(pc_out), 0);
      chk("rst_instr", 32'(instr_current), 0);
      chk("rst_req",   32'(pmem_rd_req), 0);
      chk("rst_addr",  32'(pmem_addr), 0);
      chk("rst_busy",  32'(fetch_busy), 0);
      chk("rst_flags", 32'({stack_overflow, stack_underflow, stack_conflict}), 0);
      step();
      rst = 1'b1;
      step();

      // three increments then a fetch with two cycles of request
      incr_pc_en = 1;
      repeat (3) step();
      incr_pc_en = 0;
      chk("pc_after_incr3", 32'(pc_out), 3);
      instr_rd_en = 1;
      step();
      instr_rd_en = 0;
      chk("fetch_req_c1",  32'(pmem_rd_req), 1);
      chk("fetch_addr",    32'(pmem_addr), 3);
      chk("fetch_busy_c1", 32'(fetch_busy), 1);
      step();
      chk("fetch_req_c2",  32'(pmem_rd_req), 1);
      pmem_rd_valid = 1; pmem_rd_data = 14'h3005;
      step();
      pmem_rd_valid = 0;
      chk("fetch_req_done", 32'(pmem_rd_req), 0);
      chk("fetch_instr",    32'(instr_current), 32'h3005);
      chk("fetch_busy_end", 32'(fetch_busy), 0);

      // valid while idle must not disturb the instruction register
      pmem_rd_valid = 1; pmem_rd_data = 14'h1111;
      step();
      pmem_rd_valid = 0;
      chk("idle_valid_ignored", 32'(instr_current), 32'h3005);

      // PC wrap and load-over-increment priority
      pc_load_en = 1; pc_load_addr = 13'h1FFF;
      step();
      pc_load_en = 0; incr_pc_en = 1;
      step();
      chk("pc_wrap", 32'(pc_out), 0);
      pc_load_en = 1; pc_load_addr = 13'h0123;
      step();
      pc_load_en = 0; incr_pc_en = 0;
      chk("load_beats_incr", 32'(pc_out), 32'h0123);

      // nine pushes at 0x10..0x18, eight pops, then an underflowing pop
      pc_load_en = 1; pc_load_addr = 13'h0010;
      step();
      pc_load_en = 0;
      stack_push_en = 1; incr_pc_en = 1;
      repeat (9) step();
      stack_push_en = 0; incr_pc_en = 0;
      chk("pc_after_pushes", 32'(pc_out), 32'h19);
      chk("overflow_set",    32'(stack_overflow), 1);
      chk("no_underflow_yet", 32'(stack_underflow), 0);
      stack_pop_en = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk($sformatf("pop_%0d", i), 32'(pc_out), 32'h18 - i);
      end
      chk("no_underflow_8pops", 32'(stack_underflow), 0);
      step();
      stack_pop_en = 0;
      chk("underflow_set", 32'(stack_underflow), 1);
      chk("pop9_pc",       32'(pc_out), 32'h18);

      // push at 0x40, then push+pop conflict must leave stack alone
      pc_load_en = 1; pc_load_addr = 13'h0040;
      step();
      pc_load_en = 0; stack_push_en = 1;
      step();
      chk("no_conflict_yet", 32'(stack_conflict), 0);
      stack_pop_en = 1;
      step();
      stack_push_en = 0; stack_pop_en = 0;
      chk("conflict_pc",  32'(pc_out), 32'h40);
      chk("conflict_set", 32'(stack_conflict), 1);
      pc_load_en = 1; pc_load_addr = 13'h0077;
      step();
      pc_load_en = 0; stack_pop_en = 1;
      step();
      stack_pop_en = 0;
      chk("stack_kept", 32'(pc_out), 32'h40);

      // flush while idle wins over a same-cycle read
      flush_en = 1; instr_rd_en = 1;
      step();
      flush_en = 0; instr_rd_en = 0;
      chk("idle_flush_instr", 32'(instr_current), 0);
      chk("idle_flush_noreq", 32'(pmem_rd_req), 0);

      // flush in REQ, data 0x2ABC arrives later and is dropped
      pmem_rd_data = 14'h2ABC;
      instr_rd_en = 1;
      step();
      instr_rd_en = 0;
      chk("fl_req",  32'(pmem_rd_req), 1);
      chk("fl_addr", 32'(pmem_addr), 32'h40);
      flush_en = 1;
      step();
      flush_en = 0;
      chk("fl_instr_c1", 32'(instr_current), 0);
      chk("fl_req_held", 32'(pmem_rd_req), 1);
      step();
      chk("fl_busy_drop", 32'(fetch_busy), 1);
      pmem_rd_valid = 1;
      step();
      pmem_rd_valid = 0;
      chk("fl_instr_end", 32'(instr_current), 0);
      chk("fl_req_end",   32'(pmem_rd_req), 0);
      chk("fl_busy_end",  32'(fetch_busy), 0);
      instr_rd_en = 1;
      step();
      instr_rd_en = 0;
      chk("fl_back_idle", 32'(pmem_rd_req), 1);
      pmem_rd_valid = 1;
      step();
      pmem_rd_valid = 0;
      chk("post_flush_fetch", 32'(instr_current), 32'h2ABC);

      // asynchronous reset in the middle of a request
      instr_rd_en = 1;
      step();
      instr_rd_en = 0;
      chk("pre_rst_req", 32'(pmem_rd_req), 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_req",   32'(pmem_rd_req), 0);
      chk("arst_busy",  32'(fetch_busy), 0);
      chk("arst_pc",    32'(pc_out), 0);
      chk("arst_instr", 32'(instr_current), 0);
      chk("arst_flags", 32'({stack_overflow, stack_underflow, stack_conflict}), 0);
      step();
      rst = 1'b1;
      pmem_rd_valid = 1; pmem_rd_data = 14'h1234;
      step();
      pmem_rd_valid = 0;
      chk("late_valid_instr", 32'(instr_current), 0);
      chk("late_valid_req",   32'(pmem_rd_req), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
